// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory and decode.
// The fetch unit takes the master view; the memory/decode side takes slave.
interface fetch_unit_if;
    logic [31:0] npc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc_adel;
    logic [31:0] fetch_count;

    modport master (
        input  npc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, pc, exc_adel, fetch_count
    );

    modport slave (
        output npc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, pc, exc_adel, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the architectural PC, issues one word read per
// instruction to a variable-latency memory, and hands the instruction/PC pair
// to decode over valid/ready. Illegal fetch addresses skip the memory and
// present a zero instruction flagged with exc_adel.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] PC_MIN   = 32'h0000_3000,
    parameter logic [31:0] PC_MAX   = 32'h0000_6ffc
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        exc_adel_q, exc_adel_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        pc_legal;
    logic        fire;

    // Word aligned and inside the fetch window; checked fresh in every S_REQ
    // because npc is loaded unchecked.
    assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_q >= PC_MIN) && (pc_q <= PC_MAX);
    assign fire     = (state_q == S_OUT) && bus.instr_ready;

    // Request is combinational so the read goes out in the first S_REQ cycle.
    assign bus.imem_req    = (state_q == S_REQ) && pc_legal;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state_q == S_OUT);
    assign bus.instr       = instr_q;
    assign bus.pc          = pc_q;
    assign bus.exc_adel    = exc_adel_q;
    assign bus.fetch_count = fetch_count_q;

    // Next-state logic: request, wait for data, then hold the pair until decode takes it.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        exc_adel_d    = exc_adel_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            S_REQ: begin
                if (!pc_legal) begin
                    instr_d    = 32'h0;
                    exc_adel_d = 1'b1;
                    state_d    = S_OUT;
                end else if (bus.imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    instr_d    = bus.imem_rdata;
                    exc_adel_d = 1'b0;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (fire) begin
                    pc_d          = bus.npc;
                    fetch_count_d = fetch_count_q + 32'd1;
                    state_d       = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // State registers; reset also abandons any read still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            exc_adel_q    <= 1'b0;
            fetch_count_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            exc_adel_q    <= exc_adel_d;
            fetch_count_q <= fetch_count_d;
        end
    end

endmodule
